// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder for the raster blocks' line master port.
// Accepts one 64-word line read or write and serializes it into single-word beats
// on a narrow SRAM port, then pulses resp_done.
// Optional build macro LINE_RESP_PROTOCOL_CHECK_EN adds the sticky protocol_err output.
module line_mem_responder #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
) (
    input  logic                                         clk,
    input  logic                                         n_rst,
    input  logic                                         read_enable,
    input  logic                                         write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                    address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data,
    output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                         busy,
    output logic                                         resp_done,
    output logic [ADDR_SIZE_BITS-1:0]                    mem_addr,
    output logic                                         mem_re,
    output logic                                         mem_we,
    output logic [WORD_SIZE_BYTES*8-1:0]                 mem_wdata,
    input  logic [WORD_SIZE_BYTES*8-1:0]                 mem_rdata
`ifdef LINE_RESP_PROTOCOL_CHECK_EN
    ,
    output logic                                         protocol_err
`endif
);

    localparam int W     = WORD_SIZE_BYTES * 8;
    localparam int CNT_W = $clog2(DATA_SIZE_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_SIZE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, RD_BEAT, RD_TAIL, WR_BEAT, RESP} state_t;

    state_t                                 state, state_d;
    logic [CNT_W-1:0]                       cnt, cnt_d;
    logic                                   busy_d, resp_done_d, mem_re_d, mem_we_d;
    logic [ADDR_SIZE_BITS-1:0]              mem_addr_d, base_q, beat_addr;
    logic [W-1:0]                           mem_wdata_d;
    logic [W*DATA_SIZE_WORDS-1:0]           wbuf;
    logic                                   load_wr, load_rd, cap_en;
    logic [CNT_W-1:0]                       cap_idx;

    // Beat address wraps naturally at the address width.
    assign beat_addr = base_q + ADDR_SIZE_BITS'(cnt);

    // Control state and all registered port outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            resp_done <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            resp_done <= resp_done_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Next-state logic; write wins when both requests arrive together in IDLE.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        busy_d      = busy;
        resp_done_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        load_wr     = 1'b0;
        load_rd     = 1'b0;
        cap_en      = 1'b0;
        cap_idx     = cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (write_enable) begin
                    load_wr = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WR_BEAT;
                end else if (read_enable) begin
                    load_rd = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RD_BEAT;
                end
            end
            RD_BEAT: begin
                mem_re_d   = 1'b1;
                mem_addr_d = beat_addr;
                cnt_d      = cnt + CNT_W'(1);
                // Data for the previous beat's strobe is on mem_rdata now.
                cap_en     = (cnt != '0);
                if (cnt == LAST) state_d = RD_TAIL;
            end
            RD_TAIL: begin
                cap_en  = 1'b1;
                cap_idx = LAST;
                state_d = RESP;
            end
            WR_BEAT: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = beat_addr;
                mem_wdata_d = wbuf[cnt*W +: W];
                cnt_d       = cnt + CNT_W'(1);
                if (cnt == LAST) state_d = RESP;
            end
            RESP: begin
                resp_done_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches and word-by-word read data capture.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            base_q    <= '0;
            wbuf      <= '0;
            read_data <= '0;
        end else begin
            if (load_wr) begin
                base_q <= address;
                wbuf   <= write_data;
            end else if (load_rd) begin
                base_q <= address;
            end
            if (cap_en) read_data[cap_idx*W +: W] <= mem_rdata;
        end
    end

`ifdef LINE_RESP_PROTOCOL_CHECK_EN
    logic is_wr;

    // Sticky flag for a master raising the other enable mid-request or both at once.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            is_wr        <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (load_wr)      is_wr <= 1'b1;
            else if (load_rd) is_wr <= 1'b0;
            if (busy && (is_wr ? read_enable : write_enable)) protocol_err <= 1'b1;
            if (state == IDLE && read_enable && write_enable) protocol_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with an SRAM model and a beat scoreboard.
module tb_line_mem_responder;

    localparam int A  = 24;
    localparam int W  = 24;
    localparam int N  = 64;

    typedef struct {
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             read_enable, write_enable;
    logic [A-1:0]     address;
    logic [W*N-1:0]   write_data, read_data;
    logic             busy, resp_done, mem_re, mem_we;
    logic [A-1:0]     mem_addr;
    logic [W-1:0]     mem_wdata;
    logic [W-1:0]     mem_rdata = '0;
`ifdef LINE_RESP_PROTOCOL_CHECK_EN
    logic             protocol_err;
`endif

    logic [W-1:0]     sram [logic [A-1:0]];
    beat_t            exp_q [$];
    int               errors = 0;
    int               checks = 0;

    line_mem_responder #(
        .ADDR_SIZE_BITS (24),
        .WORD_SIZE_BYTES(3),
        .DATA_SIZE_WORDS(64)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .busy        (busy),
        .resp_done   (resp_done),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef LINE_RESP_PROTOCOL_CHECK_EN
        ,
        .protocol_err(protocol_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sram_rd(input logic [A-1:0] a);
        return sram.exists(a) ? sram[a] : '0;
    endfunction

    // SRAM model and beat scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        if (mem_re || mem_we) begin
            check("re_we_exclusive", {63'd0, mem_re & mem_we}, 64'd0);
            check("beat_pending", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("beat_kind", {63'd0, mem_we}, {63'd0, b.we});
                check("beat_addr", {40'd0, mem_addr}, {40'd0, b.addr});
                if (b.we) check("beat_wdata", {40'd0, mem_wdata}, {40'd0, b.data});
            end
        end
        if (mem_we) sram[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata = sram_rd(mem_addr);
    end

    task automatic push_beats(input logic we, input logic [A-1:0] base, input int count,
                              input logic [W*N-1:0] data);
        beat_t b;
        for (int n = 0; n < count; n++) begin
            b.we   = we;
            b.addr = base + A'(n);
            b.data = data[n*W +: W];
            exp_q.push_back(b);
        end
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic finish_req(input string tag, input int exp_lat);
        int lat = 0;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        read_enable  = 1'b0;
        write_enable = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (resp_done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, resp_done}, 64'd0);
        check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_beats_left"}, exp_q.size(), 0);
    endtask

    task automatic check_line(input string tag, input logic [W*N-1:0] exp);
        for (int n = 0; n < N; n++)
            check($sformatf("%s_w%0d", tag, n), {40'd0, read_data[n*W +: W]},
                  {40'd0, exp[n*W +: W]});
    endtask

    initial begin
        logic [W*N-1:0] rd_exp, wr_line, wrap_exp;
        int             bad;

        n_rst        = 1'b0;
        read_enable  = 1'b1;
        write_enable = 1'b0;
        address      = 24'h010000;
        write_data   = '0;

        // Reset held with a read request pending.
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_mem_re", {63'd0, mem_re}, 64'd0);
            check("rst_resp_done", {63'd0, resp_done}, 64'd0);
            check("rst_read_data_lo", read_data[63:0], 64'd0);
            check("rst_read_data_hi", read_data[W*N-1 -: 64], 64'd0);
        end
        read_enable = 1'b0;
        n_rst       = 1'b1;
        @(negedge clk);

        // Line read from layer 1.
        for (int n = 0; n < N; n++) begin
            sram[24'h010000 + A'(n)] = W'(n * 24'h010101);
            rd_exp[n*W +: W] = W'(n * 24'h010101);
        end
        push_beats(1'b0, 24'h010000, N, '0);
        address     = 24'h010000;
        read_enable = 1'b1;
        @(negedge clk);
        finish_req("read", 66);
        check_line("read", rd_exp);

        // Line write to layer 0; read_data must keep the previous line.
        for (int n = 0; n < N; n++) wr_line[n*W +: W] = 24'hFF0000 | W'(n);
        push_beats(1'b1, 24'h000200, N, wr_line);
        address      = 24'h000200;
        write_data   = wr_line;
        write_enable = 1'b1;
        @(negedge clk);
        finish_req("write", 65);
        bad = 0;
        for (int n = 0; n < N; n++)
            if (sram_rd(24'h000200 + A'(n)) !== (24'hFF0000 | W'(n))) bad++;
        check("write_sram_words_bad", bad, 0);
        check_line("write_keep", rd_exp);
`ifdef LINE_RESP_PROTOCOL_CHECK_EN
        check("perr_clean", {63'd0, protocol_err}, 64'd0);
`endif

        // Simultaneous request: write wins.
        for (int n = 0; n < N; n++) wr_line[n*W +: W] = 24'h00AB00 | W'(n);
        push_beats(1'b1, 24'h000400, N, wr_line);
        address      = 24'h000400;
        write_data   = wr_line;
        read_enable  = 1'b1;
        write_enable = 1'b1;
        @(negedge clk);
        finish_req("both", 65);
        check("both_sram_last", {40'd0, sram_rd(24'h00043F)}, 64'h00AB3F);
        check_line("both_keep", rd_exp);
`ifdef LINE_RESP_PROTOCOL_CHECK_EN
        check("perr_both", {63'd0, protocol_err}, 64'd1);
`endif

        // Wrap-around read near the top of the address space.
        for (int n = 0; n < N; n++) begin
            sram[24'hFFFFF0 + A'(n)] = W'(24'h5A0000 + n * 3);
            wrap_exp[n*W +: W] = W'(24'h5A0000 + n * 3);
        end
        push_beats(1'b0, 24'hFFFFF0, N, '0);
        check("wrap_beat16_addr", {40'd0, exp_q[16].addr}, 64'h000000);
        check("wrap_beat63_addr", {40'd0, exp_q[63].addr}, 64'h00002F);
        address     = 24'hFFFFF0;
        read_enable = 1'b1;
        @(negedge clk);
        finish_req("wrap", 66);
        check_line("wrap", wrap_exp);

        // Reset at beat 10 of a write.
        for (int n = 0; n < N; n++) wr_line[n*W +: W] = 24'h0F0F00 | W'(n);
        push_beats(1'b1, 24'h000800, 11, wr_line);
        address      = 24'h000800;
        write_data   = wr_line;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        bad = 1;
        for (int k = 0; k < 80; k++) begin
            if (mem_we && mem_addr == 24'h00080A) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_beat10", bad, 0);
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_we_dropped", {63'd0, mem_we}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        n_rst = 1'b1;
        bad = 0;
        repeat (70) begin
            @(negedge clk);
            if (resp_done || mem_we || mem_re) bad++;
        end
        check("midrst_quiet_cycles", bad, 0);
        check("midrst_no_beat11", {63'd0, sram.exists(24'h00080B)}, 64'd0);
        check("midrst_beats_left", exp_q.size(), 0);

        // Fresh read after the aborted write.
        push_beats(1'b0, 24'h010000, N, '0);
        address     = 24'h010000;
        read_enable = 1'b1;
        @(negedge clk);
        finish_req("reread", 66);
        check_line("reread", rd_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
